usb11_port_ctrl: RTL and testbench

Parametrised successor of the single-port USB 1.1 host controller. It runs in the 12 MHz USB domain. Internally it provides:
- a single-clock command FIFO;
- a command-execution FSM;
- a frame (EOF) timer;
- per-channel reset/enable registers that apply only on frame boundaries;
- line-state sampling for NUM_CH ports.

It sits between the host-side CDC FIFO pair and the per-channel serializers. It issues transmit bytes to the serializers through a valid/ready handshake.

---
 rtl/usb11_port_ctrl_if.sv | 21 ++
 rtl/usb11_port_ctrl.sv | 123 ++++++++++++
 tb/tb_usb11_port_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb11_port_ctrl_if.sv
// usb11_port_ctrl_if: command, transmit and result handshakes of the port controller.
interface usb11_port_ctrl_if;
   logic [15:0] cmd_data;
   logic        cmd_wr;
   logic        cmd_full;
   logic [7:0]  tx_byte;
   logic [3:0]  tx_ch;
   logic        tx_valid;
   logic        tx_ready;
   logic [15:0] res_data;
   logic        res_valid;
   logic        res_ready;
   modport master (
      output cmd_data, cmd_wr, tx_ready, res_ready,
      input  cmd_full, tx_byte, tx_ch, tx_valid, res_data, res_valid
   );
   modport slave (
      input  cmd_data, cmd_wr, tx_ready, res_ready,
      output cmd_full, tx_byte, tx_ch, tx_valid, res_data, res_valid
   );
endinterface

// File: rtl/usb11_port_ctrl.sv
// usb11_port_ctrl: multi-port USB 1.1 command engine with frame-aligned port control.
// Optional USB11_LINE_EVT_EN reports line-state changes on enabled ports.
module usb11_port_ctrl #(
   parameter int NUM_CH     = 2,
   parameter int CMD_AW     = 4,
   parameter int FRAME_CLKS = 12000
) (
   input  logic              clk,
   input  logic              reset,
   usb11_port_ctrl_if.slave  bus,
   input  logic [NUM_CH-1:0] line_dp,
   input  logic [NUM_CH-1:0] line_dm,
   output logic [NUM_CH-1:0] port_se0,
   output logic [NUM_CH-1:0] port_en,
   output logic              eof
);
   localparam int DEPTH = 1 << CMD_AW;
   localparam int FW    = $clog2(FRAME_CLKS);
   typedef enum logic [2:0] {IDLE, FETCH, EXEC, TX_WAIT, RES_WAIT} state_t;
   state_t state, state_n;
   logic [15:0] mem [DEPTH];
   logic [15:0] cmd_q, evt_word;
   logic [CMD_AW-1:0] wp, rp;
   logic [CMD_AW:0] cnt, cnt_n;
   logic [FW-1:0] fcnt;
   logic [NUM_CH-1:0] dp1, dm1, dp_s, dm_s, pend_rst, pend_en, sel;
   logic [3:0] op, ch;
   logic push, pop, empty, exec, evt_take;
   assign op = cmd_q[15:12];
   assign ch = cmd_q[11:8];
   // Out-of-range channels shift the one-hot select to zero, turning the command into a NOP.
   assign sel = NUM_CH'(1) << ch;
   assign exec = state == EXEC && |sel;
   assign empty = cnt == '0;
   assign pop = state == FETCH;
   assign push = bus.cmd_wr & (~bus.cmd_full | pop);
   assign cnt_n = cnt + (CMD_AW+1)'(push) - (CMD_AW+1)'(pop);
   assign eof = fcnt == FW'(FRAME_CLKS-1);
   assign bus.tx_valid = state == TX_WAIT;
   assign bus.res_valid = state == RES_WAIT;
   always_comb begin
      state_n = state;
      case (state)
         IDLE:     state_n = !empty ? FETCH : evt_take ? RES_WAIT : IDLE;
         FETCH:    state_n = EXEC;
         EXEC:     state_n = exec && op == 4'd4 ? TX_WAIT : exec && op == 4'd3 ? RES_WAIT : IDLE;
         TX_WAIT:  state_n = bus.tx_ready ? IDLE : TX_WAIT;
         RES_WAIT: state_n = bus.res_ready ? IDLE : RES_WAIT;
         default:  state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk)
      if (push) mem[wp] <= bus.cmd_data;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state        <= IDLE;
         wp           <= '0;
         rp           <= '0;
         cnt          <= '0;
         bus.cmd_full <= 1'b0;
         fcnt         <= '0;
         {dp1, dp_s, dm1, dm_s} <= '0;
         {pend_rst, pend_en, port_se0, port_en} <= '0;
         cmd_q        <= '0;
         bus.tx_byte  <= '0;
         bus.tx_ch    <= '0;
         bus.res_data <= '0;
      end else begin
         state        <= state_n;
         cnt          <= cnt_n;
         bus.cmd_full <= cnt_n == (CMD_AW+1)'(DEPTH);
         fcnt         <= eof ? '0 : fcnt + 1'b1;
         {dp_s, dp1}  <= {dp1, line_dp};
         {dm_s, dm1}  <= {dm1, line_dm};
         if (push) wp <= wp + 1'b1;
         if (pop) begin
            rp    <= rp + 1'b1;
            cmd_q <= mem[rp];
         end
         if (exec && op == 4'd1) pend_rst <= (pend_rst & ~sel) | ({NUM_CH{cmd_q[0]}} & sel);
         if (exec && op == 4'd2) pend_en <= (pend_en & ~sel) | ({NUM_CH{cmd_q[0]}} & sel);
         if (exec && op == 4'd4) begin
            bus.tx_byte <= cmd_q[7:0];
            bus.tx_ch   <= ch;
         end
         if (exec && op == 4'd3) bus.res_data <= {4'h1, ch, 6'h0, |(dp_s & sel), |(dm_s & sel)};
         else if (evt_take) bus.res_data <= evt_word;
         // Port state only moves on the frame boundary so the serializers see whole frames.
         if (eof) begin
            port_se0 <= pend_rst;
            port_en  <= pend_en;
         end
      end
`ifdef USB11_LINE_EVT_EN
   logic [NUM_CH-1:0] prev_dp, prev_dm, evt, chg, done, esel;
   logic [3:0] evt_ch;
   assign chg = port_en & ((dp_s ^ prev_dp) | (dm_s ^ prev_dm));
   assign esel = NUM_CH'(1) << evt_ch;
   // Only event results (tag 2) retire a pending bit; READ_LINES results leave them alone.
   assign done = state == RES_WAIT && bus.res_ready && bus.res_data[15:12] == 4'h2 ?
                 NUM_CH'(1) << bus.res_data[11:8] : '0;
   assign evt_take = state == IDLE && empty && |evt;
   assign evt_word = {4'h2, evt_ch, 6'h0, |(dp_s & esel), |(dm_s & esel)};
   always_comb begin
      evt_ch = '0;
      for (int i = NUM_CH-1; i >= 0; i--)
         if (evt[i]) evt_ch = 4'(i);
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         prev_dp <= '0;
         prev_dm <= '0;
         evt     <= '0;
      end else begin
         prev_dp <= dp_s;
         prev_dm <= dm_s;
         evt     <= (evt & ~done) | chg;
      end
`else
   assign evt_take = 1'b0;
   assign evt_word = '0;
`endif
endmodule

// File: tb/tb_usb11_port_ctrl.sv
// tb_usb11_port_ctrl: directed self-checking bench for usb11_port_ctrl.
module tb_usb11_port_ctrl;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [1:0] line_dp = '0;
   logic [1:0] line_dm = '0;
   logic [1:0] port_se0, port_en;
   logic eof;
   int checks = 0;
   int errors = 0;
   int t = 0;
   usb11_port_ctrl_if bus();
   usb11_port_ctrl #(.NUM_CH(2), .CMD_AW(4), .FRAME_CLKS(12000)) dut (
      .clk(clk), .reset(reset), .bus(bus), .line_dp(line_dp), .line_dm(line_dm),
      .port_se0(port_se0), .port_en(port_en), .eof(eof)
   );
   always #5 clk = ~clk;
   initial begin
      #1ms;
      $display("FAIL watchdog expired at t=%0d", t);
      $fatal(1);
   end
   task tick;
      @(negedge clk);
      t++;
   endtask
   task push(input logic [15:0] w);
      bus.cmd_data = w;
      bus.cmd_wr = 1'b1;
      tick();
      bus.cmd_wr = 1'b0;
   endtask
   task wait_tx(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.tx_valid) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask
   task wait_res(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.res_valid) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask
   task test_reset;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      t = 0;
      checks++;
      if ({bus.tx_valid, bus.res_valid, bus.cmd_full, eof} !== 4'b0) begin
         errors++;
         $display("FAIL reset_flags got %b want 0000", {bus.tx_valid, bus.res_valid, bus.cmd_full, eof});
      end
      checks++;
      if ({port_se0, port_en, bus.tx_byte, bus.tx_ch, bus.res_data} !== '0) begin
         errors++;
         $display("FAIL reset_data got se0=%b en=%b tx=%h ch=%h res=%h want all 0",
                  port_se0, port_en, bus.tx_byte, bus.tx_ch, bus.res_data);
      end
   endtask
   task test_frame_apply;
      bit bad, early;
      while (t < 100) tick();
      push(16'h1001);
      push(16'h2001);
      bad = 1'b0;
      early = 1'b0;
      while (t < 11999) begin
         if (port_se0[0] | port_en[0]) bad = 1'b1;
         if (eof) early = 1'b1;
         tick();
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL frame_hold got early port change want none before eof");
      end
      checks++;
      if (early) begin
         errors++;
         $display("FAIL frame_early_eof got eof before 11999 want none");
      end
      checks++;
      if (eof !== 1'b1 || port_se0 !== 2'b00 || port_en !== 2'b00) begin
         errors++;
         $display("FAIL frame_eof got eof=%b se0=%b en=%b want 1 00 00", eof, port_se0, port_en);
      end
      tick();
      checks++;
      if (eof !== 1'b0 || port_se0 !== 2'b01 || port_en !== 2'b01) begin
         errors++;
         $display("FAIL frame_apply got eof=%b se0=%b en=%b want 0 01 01", eof, port_se0, port_en);
      end
   endtask
   task test_read_lines;
      bit ok, bad;
      line_dp = 2'b10;
      line_dm = 2'b00;
      repeat (3) tick();
      push(16'h3100);
      wait_res(ok);
      checks++;
      if (!ok || bus.res_data !== 16'h1102) begin
         errors++;
         $display("FAIL read_lines got valid=%b data=%h want 1 1102", ok, bus.res_data);
      end
      bad = 1'b0;
      repeat (5) begin
         tick();
         if (bus.res_valid !== 1'b1 || bus.res_data !== 16'h1102) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL read_hold got unstable result want 1102 held");
      end
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
      checks++;
      if (bus.res_valid !== 1'b0) begin
         errors++;
         $display("FAIL read_release got res_valid=%b want 0", bus.res_valid);
      end
   endtask
   task test_send_byte;
      bit ok, bad;
      int n;
      bus.tx_ready = 1'b0;
      push(16'h41A5);
      wait_tx(ok);
      checks++;
      if (!ok || bus.tx_byte !== 8'hA5 || bus.tx_ch !== 4'h1) begin
         errors++;
         $display("FAIL send_byte got valid=%b byte=%h ch=%h want 1 a5 1", ok, bus.tx_byte, bus.tx_ch);
      end
      bad = 1'b0;
      repeat (10) begin
         tick();
         if (bus.tx_valid !== 1'b1 || bus.tx_byte !== 8'hA5 || bus.tx_ch !== 4'h1) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL send_hold got unstable tx want a5/1 held");
      end
      bus.tx_ready = 1'b1;
      n = 0;
      repeat (6) begin
         if (bus.tx_valid) n++;
         tick();
      end
      bus.tx_ready = 1'b0;
      checks++;
      if (n != 1 || bus.tx_valid !== 1'b0) begin
         errors++;
         $display("FAIL send_once got transfers=%0d valid=%b want 1 0", n, bus.tx_valid);
      end
   endtask
   task test_fifo_full;
      bit ok, bad;
      logic [7:0] got[$];
      bus.tx_ready = 1'b0;
      push(16'h4011);
      wait_tx(ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL fifo_stall got tx_valid=0 want 1");
      end
      for (int i = 0; i < 16; i++) push(16'h4020 + 16'(i));
      checks++;
      if (bus.cmd_full !== 1'b1) begin
         errors++;
         $display("FAIL fifo_full got %b want 1", bus.cmd_full);
      end
      push(16'h4030);
      bus.tx_ready = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if (bus.tx_valid) got.push_back(bus.tx_byte);
         tick();
      end
      bus.tx_ready = 1'b0;
      checks++;
      if (got.size() != 17) begin
         errors++;
         $display("FAIL fifo_count got %0d want 17", got.size());
      end
      bad = got.size() == 0 || got[0] !== 8'h11;
      for (int i = 1; i < got.size(); i++)
         if (got[i] !== 8'h20 + 8'(i - 1)) bad = 1'b1;
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL fifo_order got first=%h last=%h want 11 then 20..2f",
                  got.size() > 0 ? got[0] : 8'h00, got.size() > 0 ? got[got.size()-1] : 8'h00);
      end
      checks++;
      if (bus.cmd_full !== 1'b0) begin
         errors++;
         $display("FAIL fifo_drain got cmd_full=%b want 0", bus.cmd_full);
      end
   endtask
   task test_bad_channel;
      bit ok, bad;
      push(16'h2F01);
      bad = 1'b0;
      repeat (8) begin
         if (bus.tx_valid | bus.res_valid) bad = 1'b1;
         tick();
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL bad_channel got output activity want none");
      end
      push(16'h3000);
      wait_res(ok);
      checks++;
      if (!ok || bus.res_data !== 16'h1000) begin
         errors++;
         $display("FAIL bad_channel_idle got valid=%b data=%h want 1 1000", ok, bus.res_data);
      end
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
   endtask
   task test_reset_mid;
      bit ok, bad, early;
      bus.tx_ready = 1'b0;
      push(16'h4133);
      wait_tx(ok);
      push(16'h3000);
      push(16'h4044);
      #2 reset = 1'b1;
      #1;
      checks++;
      if (bus.tx_valid !== 1'b0 || bus.tx_byte !== 8'h00 || bus.cmd_full !== 1'b0) begin
         errors++;
         $display("FAIL reset_async got valid=%b byte=%h full=%b want 0 00 0",
                  bus.tx_valid, bus.tx_byte, bus.cmd_full);
      end
      @(negedge clk);
      reset = 1'b0;
      t = 0;
      bad = 1'b0;
      repeat (10) begin
         tick();
         if (bus.tx_valid | bus.res_valid) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL reset_fifo_empty got stale command executed want none");
      end
      push(16'h1201);
      push(16'h2001);
      early = 1'b0;
      while (t < 11999) begin
         if (eof) early = 1'b1;
         tick();
      end
      checks++;
      if (early || eof !== 1'b1) begin
         errors++;
         $display("FAIL reset_frame got early=%b eof=%b want 0 1 at t=11999", early, eof);
      end
      tick();
      checks++;
      if (port_se0 !== 2'b00 || port_en !== 2'b01) begin
         errors++;
         $display("FAIL reset_ports got se0=%b en=%b want 00 01", port_se0, port_en);
      end
   endtask
`ifdef USB11_LINE_EVT_EN
   task test_line_event;
      bit ok, bad;
      repeat (3) tick();
      checks++;
      if (bus.res_valid !== 1'b0) begin
         errors++;
         $display("FAIL event_quiet got res_valid=1 want 0");
      end
      line_dm[0] = 1'b1;
      wait_res(ok);
      checks++;
      if (!ok || bus.res_data !== 16'h2001) begin
         errors++;
         $display("FAIL event_word got valid=%b data=%h want 1 2001", ok, bus.res_data);
      end
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
      bad = 1'b0;
      repeat (6) begin
         if (bus.res_valid) bad = 1'b1;
         tick();
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL event_clear got repeated event want one");
      end
   endtask
`endif
   initial begin
      bus.cmd_data = '0;
      bus.cmd_wr = 1'b0;
      bus.tx_ready = 1'b0;
      bus.res_ready = 1'b0;
      test_reset();
      test_frame_apply();
      test_read_lines();
      test_send_byte();
      test_fifo_full();
      test_bad_channel();
      test_reset_mid();
`ifdef USB11_LINE_EVT_EN
      test_line_event();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
